// File: rtl/clock_divider_multi_if.sv
// Control and output bundle for the multi-channel divider.
// The bench drives it as master; the divider core uses it as slave.
interface clock_divider_multi_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 28
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] enable;
    logic                load;
    logic [CW-1:0]       load_ch;
    logic [WIDTH-1:0]    load_div;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    modport master (
        output enable, load, load_ch, load_div,
        input  clk_out, tick
    );

    modport slave (
        input  enable, load, load_ch, load_div,
        output clk_out, tick
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable divider with a ~50% duty clock and a wrap tick per channel.
// Each channel reloads its divisor at its own wrap, so no period is ever cut short.
module clock_divider_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic                  clock_in,
    input  logic                  reset,
    clock_divider_multi_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] load_val;

    assign load_val = (bus.load_div < MIN_DIV) ? MIN_DIV : bus.load_div;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] active_div;
        logic [WIDTH-1:0] shadow_div;
        logic             pend;
        logic             clk_r;
        logic             tick_r;
        logic             en;
        logic             hit;
        logic             wrap;

        assign en   = bus.enable[i];
        // An out-of-range load_ch simply matches no channel.
        assign hit  = bus.load && (32'(bus.load_ch) == 32'(i));
        // >= rather than == lets a counter that overshot a shrunk divisor recover.
        assign wrap = (cnt >= active_div - ONE);

        always_ff @(posedge clock_in or posedge reset) begin
            if (reset) begin
                cnt        <= '0;
                active_div <= DEF_DIV;
                shadow_div <= DEF_DIV;
                pend       <= 1'b0;
                clk_r      <= 1'b0;
                tick_r     <= 1'b0;
            end else begin
                if (en) begin
                    clk_r  <= (cnt < (active_div >> 1));
                    tick_r <= (cnt == active_div - ONE);
                    cnt    <= wrap ? '0 : cnt + ONE;
                end else begin
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                    cnt    <= '0;
                end

                if (hit) begin
                    shadow_div <= load_val;
                    if (!en || wrap) begin
                        active_div <= load_val;
                        pend       <= 1'b0;
                    end else begin
                        pend       <= 1'b1;
                    end
                end else if (en && wrap && pend) begin
                    active_div <= shadow_div;
                    pend       <= 1'b0;
                end
            end
        end

        assign bus.clk_out[i] = clk_r;
        assign bus.tick[i]    = tick_r;
    end
endmodule
